// File: rtl/ex_muldiv_unit_if.sv
// Operand/control bundle between the EX stage and the RV32M multiply/divide unit.
// Pipeline side uses master; the unit uses slave.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit; 33-cycle ops, 1-cycle div special cases.
// Stalls the pipeline while busy. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_neg;
  logic [5:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_special_res;

  // Operand decode on the live inputs; only consumed at acceptance.
  assign w_is_div   = bus.funct3[2];
  assign w_a_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_a_neg    = w_a_signed & bus.rs1_data[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.rs2_data[XLEN-1];
  assign w_a_mag    = w_a_neg ? (XLEN'(0) - bus.rs1_data) : bus.rs1_data;
  assign w_b_mag    = w_b_neg ? (XLEN'(0) - bus.rs2_data) : bus.rs2_data;
  assign w_neg      = (w_is_div & bus.funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div0 = w_is_div & (bus.rs2_data == '0);
  assign w_ovf  = w_is_div & ~bus.funct3[0] & (bus.rs1_data == MIN_NEG) & (bus.rs2_data == '1);
  assign w_special_res = w_div0 ? (bus.funct3[1] ? bus.rs1_data : '1)
                                : (bus.funct3[1] ? '0 : MIN_NEG);

  // Shift-add step: conditionally add multiplicand to the high half, then shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_mul_res;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
  assign w_acc_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_prod_fin = r_neg ? ((2*XLEN)'(0) - w_acc_nxt) : w_acc_nxt;
  assign w_mul_res  = (r_op == 2'b00) ? w_prod_fin[XLEN-1:0] : w_prod_fin[2*XLEN-1:XLEN];

  // Restoring step: the shifted remainder is XLEN+1 bits wide, compared with a borrow bit.
  logic [XLEN:0]     w_shift;
  logic [XLEN+1:0]   w_diff;
  logic              w_qbit;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;
  logic [XLEN-1:0]   w_div_val;
  logic [XLEN-1:0]   w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = {1'b0, w_shift} - {2'b00, r_b};
  assign w_qbit    = ~w_diff[XLEN+1];
  assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
  assign w_div_val = r_op[1] ? w_rem_nxt : w_quo_nxt;
  assign w_div_res = r_neg ? (XLEN'(0) - w_div_val) : w_div_val;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  logic [2*XLEN-1:0] w_fast_fin;
  logic [XLEN-1:0]   w_fast_res;

  assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
  assign w_fast_fin  = w_neg ? ((2*XLEN)'(0) - w_fast_prod) : w_fast_prod;
  assign w_fast_res  = (bus.funct3[1:0] == 2'b00) ? w_fast_fin[XLEN-1:0] : w_fast_fin[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op  <= bus.funct3[1:0];
            r_a   <= w_a_mag;
            r_b   <= w_b_mag;
            r_neg <= w_neg;
            r_cnt <= '0;
            if (w_div0 || w_ovf) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_is_div) begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_busy  <= 1'b1;
              r_state <= S_DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`else
              r_acc   <= {{XLEN{1'b0}}, w_b_mag};
              r_busy  <= 1'b1;
              r_state <= S_MUL;
`endif
            end
          end
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_result <= w_mul_res;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_result <= w_div_res;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Same instruction is still in EX; start is ignored here.
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall  = bus.start & ~r_done;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush/reset aborts,
// back-to-back issue and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(32)) mif();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [31:0] last_res;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic with the RISC-V division corner rules.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (sa == -64'sd2147483648 && sb == -64'sd1) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (sa == -64'sd2147483648 && sb == -64'sd1) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Presents an op in the current (IDLE) cycle T, returns in the done cycle with start still high.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, output int dcyc);
    int  l;
    bit  got;
    l = ref_lat(f, a, b);
    got = 1'b0;
    dcyc = 0;
    mif.start = 1'b1;
    mif.flush = 1'b0;
    mif.funct3 = f;
    mif.rs1_data = a;
    mif.rs2_data = b;
    #1;
    check({tag, "_stall_T"}, 32'(mif.stall), 32'd1);
    check({tag, "_busy_T"}, 32'(mif.busy), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mif.done === 1'b1) begin
        check({tag, "_latency"}, 32'(k), 32'(l));
        check({tag, "_result"}, mif.result, exp);
        check({tag, "_stall_done"}, 32'(mif.stall), 32'd0);
        check({tag, "_busy_done"}, 32'(mif.busy), 32'd0);
        got = 1'b1;
        dcyc = cyc;
        break;
      end
      check({tag, "_stall"}, 32'(mif.stall), 32'd1);
      check({tag, "_busy"}, 32'(mif.busy), (l == 33) ? 32'd1 : 32'd0);
      // Forwarding path changes after acceptance must not matter.
      mif.rs1_data = $urandom;
      mif.rs2_data = $urandom;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    last_res = exp;
  endtask

  task automatic idle_cycle(input string tag);
    mif.start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, 32'(mif.done), 32'd0);
    check({tag, "_hold"}, mif.result, last_res);
    check({tag, "_stall_idle"}, 32'(mif.stall), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d1, d2, dtmp;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int sel;

    dir[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    dir[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    dir[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    dir[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    dir[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    dir[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    dir[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    dir[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    dir[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    dir[9]  = '{3'd6, 32'd5,         32'd0,         32'd5};
    dir[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    dir[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    rst = 1'b1;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.funct3 = 3'd0;
    mif.rs1_data = 32'h0;
    mif.rs2_data = 32'h0;
    repeat (3) tick();
    check("rst_busy", 32'(mif.busy), 32'd0);
    check("rst_done", 32'(mif.done), 32'd0);
    check("rst_result", mif.result, 32'd0);
    check("rst_stall", 32'(mif.stall), 32'd0);
    rst = 1'b0;
    last_res = 32'h0;
    tick();

    foreach (dir[i]) begin
      run_op($sformatf("dir%0d", i), dir[i].f, dir[i].a, dir[i].b, dir[i].exp, dtmp);
      idle_cycle($sformatf("dir%0d", i));
    end

    // Flush a long DIVU mid-flight, then issue MUL 3x4 right away.
    mif.start = 1'b1;
    mif.funct3 = 3'd5;
    mif.rs1_data = 32'd1000;
    mif.rs2_data = 32'd3;
    for (int i = 1; i <= 10; i++) tick();
    mif.flush = 1'b1;
    tick();
    check("flush_busy", 32'(mif.busy), 32'd0);
    check("flush_done", 32'(mif.done), 32'd0);
    check("flush_result", mif.result, last_res);
    run_op("post_flush_mul", 3'd0, 32'd3, 32'd4, 32'd12, dtmp);
    idle_cycle("post_flush_mul");

    // flush together with start in IDLE must not accept.
    mif.start = 1'b1;
    mif.flush = 1'b1;
    mif.funct3 = 3'd5;
    mif.rs1_data = 32'd50;
    mif.rs2_data = 32'd5;
    tick();
    check("flush_start_busy", 32'(mif.busy), 32'd0);
    check("flush_start_done", 32'(mif.done), 32'd0);
    mif.flush = 1'b0;
    mif.start = 1'b0;
    tick();
    check("flush_start_busy2", 32'(mif.busy), 32'd0);
    check("flush_start_done2", 32'(mif.done), 32'd0);

    // Reset in the middle of a division.
    mif.start = 1'b1;
    mif.funct3 = 3'd4;
    mif.rs1_data = 32'd1000;
    mif.rs2_data = 32'd7;
    repeat (5) tick();
    rst = 1'b1;
    mif.start = 1'b0;
    tick();
    check("midrst_busy", 32'(mif.busy), 32'd0);
    check("midrst_done", 32'(mif.done), 32'd0);
    check("midrst_result", mif.result, 32'd0);
    check("midrst_stall", 32'(mif.stall), 32'd0);
    rst = 1'b0;
    last_res = 32'h0;
    tick();

    // Back-to-back: second op presented in the cycle after done; pulses are 34 edges apart
    // (33 non-done cycles in between).
    run_op("b2b_divu", 3'd5, 32'd9, 32'd3, 32'd3, d1);
    tick();
    run_op("b2b_remu", 3'd7, 32'd9, 32'd4, 32'd1, d2);
    check("b2b_spacing", 32'(d2 - d1), 32'd34);
    idle_cycle("b2b");

    for (int i = 0; i < 24; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, ref_model(rf, ra, rb), dtmp);
      idle_cycle($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
